image_loader: RTL and testbench

- Writer side of the input image RAM. Receives a framed 64x64 8-bit grayscale image as a byte stream with a valid/ready handshake, typically from a UART receiver.
- Writes the pixels into the 4096x8 input RAM through the RAM write port, checks a frame checksum, then holds enable_start high for the edge-detection coprocessor until that coprocessor reports completion.
- Sits between the byte source and the input RAM. Its partner is the coprocessor, which reads that RAM.

---
 rtl/image_loader.sv | 161 ++++++++++++++++
 tb/tb_image_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// Byte-stream frame loader: sync byte, NUM_PIXELS pixels, 8-bit checksum.
// Writes pixels into the input RAM, then requests a coprocessor run until it reports done.
module image_loader #(
    parameter int          NUM_PIXELS     = 4096,
    parameter int          ADDR_W         = 12,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 5000000
) (
    input  logic              clock_50MHz,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] wraddress,
    output logic [7:0]        data,
    output logic              wren,
    output logic              enable_start,
    input  logic              acabou,
    output logic              ocupado,
    output logic              erro,
    output logic              frame_ok
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECEBE, CHECKSUM, START} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              acabou_q;
    logic              rx_ready_q, rx_ready_d;
    logic [ADDR_W-1:0] wraddress_q, wraddress_d;
    logic [7:0]        data_q, data_d;
    logic              wren_q, wren_d;
    logic              enable_start_q, enable_start_d;
    logic              ocupado_q, ocupado_d;
    logic              erro_q, erro_d;
    logic              frame_ok_q, frame_ok_d;

    logic accept;
    logic tmo_hit;

    assign accept  = rx_valid && rx_ready_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        erro_d      = erro_q;
        wraddress_d = wraddress_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        frame_ok_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    erro_d  = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RECEBE;
                end
            end
            RECEBE: begin
                // An accepted byte wins over a timeout in the same cycle
                if (accept) begin
                    wren_d      = 1'b1;
                    wraddress_d = idx_q;
                    data_d      = rx_data;
                    sum_d       = sum_q + rx_data;
                    if (idx_q == IDX_LAST) begin
                        state_d = CHECKSUM;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end else if (tmo_hit) begin
                    erro_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECKSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        frame_ok_d = 1'b1;
                        state_d    = START;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmo_hit) begin
                    erro_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            START: begin
                if (acabou && !acabou_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept || state_d != state_q || !(state_q == RECEBE || state_q == CHECKSUM)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + CNT_W'(1);
        end

        // Level outputs are derived from the next state so they stay registered
        rx_ready_d     = (state_d != START);
        enable_start_d = (state_d == START);
        ocupado_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            sum_q          <= '0;
            tmo_q          <= '0;
            acabou_q       <= 1'b1;
            rx_ready_q     <= 1'b0;
            wraddress_q    <= '0;
            data_q         <= '0;
            wren_q         <= 1'b0;
            enable_start_q <= 1'b0;
            ocupado_q      <= 1'b0;
            erro_q         <= 1'b0;
            frame_ok_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sum_q          <= sum_d;
            tmo_q          <= tmo_d;
            acabou_q       <= acabou;
            rx_ready_q     <= rx_ready_d;
            wraddress_q    <= wraddress_d;
            data_q         <= data_d;
            wren_q         <= wren_d;
            enable_start_q <= enable_start_d;
            ocupado_q      <= ocupado_d;
            erro_q         <= erro_d;
            frame_ok_q     <= frame_ok_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign wraddress    = wraddress_q;
    assign data         = data_q;
    assign wren         = wren_q;
    assign enable_start = enable_start_q;
    assign ocupado      = ocupado_q;
    assign erro         = erro_q;
    assign frame_ok     = frame_ok_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: frames, checksum error, handshake, timeout, garbage, reset.
module tb_image_loader;

    localparam int         NPIX = 4096;
    localparam logic [7:0] SYNC = 8'hAA;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [11:0] wraddress;
    logic [7:0]  data;
    logic        wren;
    logic        enable_start;
    logic        acabou;
    logic        ocupado;
    logic        erro;
    logic        frame_ok;

    always #10 clk = ~clk;

    image_loader #(
        .NUM_PIXELS     (NPIX),
        .ADDR_W         (12),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock_50MHz  (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wraddress    (wraddress),
        .data         (data),
        .wren         (wren),
        .enable_start (enable_start),
        .acabou       (acabou),
        .ocupado      (ocupado),
        .erro         (erro),
        .frame_ok     (frame_ok)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    // RAM write-port log, filled only by the monitor
    logic [11:0] log_addr [8192];
    logic [7:0]  log_data [8192];
    int          wren_cnt = 0;
    int          fok_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren === 1'b1) begin
            log_addr[wren_cnt % 8192] <= wraddress;
            log_data[wren_cnt % 8192] <= data;
            wren_cnt <= wren_cnt + 1;
        end
        if (frame_ok === 1'b1) fok_cnt <= fok_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int i);
        if (mode == 0) return 8'(i);
        return 8'(i * 3 + 7);
    endfunction

    function automatic logic [7:0] frame_sum(input int mode);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < NPIX; i++) s = s + pix(mode, i);
        return s;
    endfunction

    // Called on a negedge; returns on the negedge right after the accepting posedge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check_val("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        acc_cyc  = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic send_pixels(input int mode, input int count);
        for (int i = 0; i < count; i++) send_byte(pix(mode, i));
    endtask

    task automatic verify_frame(input string tag, input int base, input int mode);
        int errs;
        errs = 0;
        for (int j = 0; j < NPIX; j++) begin
            if (log_addr[(base + j) % 8192] !== 12'(j) ||
                log_data[(base + j) % 8192] !== pix(mode, j)) errs++;
        end
        check_val({tag, "_wren_cnt"}, wren_cnt - base, NPIX);
        check_val({tag, "_mem_errs"}, errs, 0);
    endtask

    task automatic finish_run(input string tag);
        acabou = 1'b1;
        @(negedge clk);
        check_val({tag, "_en_drop"}, {31'd0, enable_start}, 32'd0);
        check_val({tag, "_rdy_back"}, {31'd0, rx_ready}, 32'd1);
        acabou = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fok0;
        int n;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        acabou   = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_val("rst_wren", {31'd0, wren}, 32'd0);
        check_val("rst_en", {31'd0, enable_start}, 32'd0);
        check_val("rst_ocupado", {31'd0, ocupado}, 32'd0);
        check_val("rst_erro", {31'd0, erro}, 32'd0);
        check_val("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("idle_rx_ready", {31'd0, rx_ready}, 32'd1);
        $display("reset: done");

        // Full frame, pixel[i] = i mod 256, checksum 0x00
        base = wren_cnt;
        fok0 = fok_cnt;
        send_byte(SYNC);
        check_val("f1_ocupado", {31'd0, ocupado}, 32'd1);
        send_pixels(0, NPIX);
        check_val("f1_en_before_chk", {31'd0, enable_start}, 32'd0);
        send_byte(8'h00);
        check_val("f1_en", {31'd0, enable_start}, 32'd1);
        check_val("f1_frame_ok", {31'd0, frame_ok}, 32'd1);
        check_val("f1_rx_ready_start", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        check_val("f1_frame_ok_pulse", {31'd0, frame_ok}, 32'd0);
        check_val("f1_fok_cnt", fok_cnt - fok0, 1);
        verify_frame("f1", base, 0);
        $display("frame f1: loaded");

        // Handshake while in START
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        check_val("hs_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_val("hs_no_wren", wren_cnt - base, NPIX);
        check_val("hs_en_hold", {31'd0, enable_start}, 32'd1);
        check_val("hs_ocupado", {31'd0, ocupado}, 32'd1);
        acabou = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check_val("hs_en_drop", {31'd0, enable_start}, 32'd0);
        check_val("hs_rx_ready_back", {31'd0, rx_ready}, 32'd1);
        check_val("hs_ocupado_idle", {31'd0, ocupado}, 32'd0);
        acabou = 1'b0;
        @(negedge clk);
        $display("handshake: done");

        // Checksum error
        base = wren_cnt;
        send_byte(SYNC);
        send_pixels(0, NPIX);
        send_byte(8'h01);
        check_val("ce_erro", {31'd0, erro}, 32'd1);
        check_val("ce_en", {31'd0, enable_start}, 32'd0);
        check_val("ce_ocupado", {31'd0, ocupado}, 32'd0);
        check_val("ce_frame_ok", {31'd0, frame_ok}, 32'd0);
        repeat (5) @(negedge clk);
        check_val("ce_en_later", {31'd0, enable_start}, 32'd0);
        check_val("ce_erro_sticky", {31'd0, erro}, 32'd1);
        verify_frame("ce", base, 0);
        $display("frame ce: rejected");

        // Recovery frame clears erro
        base = wren_cnt;
        send_byte(SYNC);
        check_val("rc_erro_clr", {31'd0, erro}, 32'd0);
        send_pixels(0, NPIX);
        send_byte(8'h00);
        check_val("rc_en", {31'd0, enable_start}, 32'd1);
        verify_frame("rc", base, 0);
        finish_run("rc");
        $display("frame rc: loaded");

        // Garbage before sync; 0xAA pixel inside frame is data
        base = wren_cnt;
        send_byte(8'h12);
        send_byte(8'h34);
        check_val("gb_ocupado", {31'd0, ocupado}, 32'd0);
        check_val("gb_no_wren", wren_cnt - base, 0);
        send_byte(SYNC);
        send_pixels(0, NPIX);
        send_byte(8'h00);
        check_val("gb_en", {31'd0, enable_start}, 32'd1);
        check_val("gb_first_addr", {20'd0, log_addr[base % 8192]}, 32'd0);
        check_val("gb_aa_pixel", {24'd0, log_data[(base + 170) % 8192]}, 32'hAA);
        verify_frame("gb", base, 0);
        finish_run("gb");
        $display("frame gb: loaded");

        // Timeout after 10 pixels
        base = wren_cnt;
        send_byte(SYNC);
        send_pixels(0, 10);
        n = 0;
        while (erro !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("to_erro", {31'd0, erro}, 32'd1);
        check_val("to_delay", cyc - acc_cyc, 100);
        check_val("to_ocupado", {31'd0, ocupado}, 32'd0);
        repeat (20) @(negedge clk);
        check_val("to_wren_cnt", wren_cnt - base, 10);
        check_val("to_erro_sticky", {31'd0, erro}, 32'd1);
        $display("timeout: done");

        // Reset mid-frame, while the last write pulse is on the port
        send_byte(SYNC);
        send_pixels(1, 2000);
        check_val("rm_ocupado_pre", {31'd0, ocupado}, 32'd1);
        check_val("rm_wren_pre", {31'd0, wren}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("rm_wren", {31'd0, wren}, 32'd0);
        check_val("rm_en", {31'd0, enable_start}, 32'd0);
        check_val("rm_ocupado", {31'd0, ocupado}, 32'd0);
        check_val("rm_erro", {31'd0, erro}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base = wren_cnt;
        send_byte(SYNC);
        send_pixels(1, NPIX);
        send_byte(frame_sum(1));
        check_val("rm_en_after", {31'd0, enable_start}, 32'd1);
        check_val("rm_first_addr", {20'd0, log_addr[base % 8192]}, 32'd0);
        verify_frame("rm", base, 1);
        finish_run("rm");
        $display("frame rm: loaded");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
